// File: rtl/ship_sprite_renderer_pkg.sv
// ship_pkg: shared screen/sprite constants, key codes and FSM state type
// for the ship sprite renderer.
package ship_pkg;
   localparam int SHIP_W   = 16;
   localparam int SHIP_H   = 8;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam logic [7:0] KEY_LEFT  = 8'h04;
   localparam logic [7:0] KEY_RIGHT = 8'h07;
   typedef enum logic {ALIVE, HIT} ship_state_t;
endpackage

// File: rtl/ship_sprite_renderer_motion.sv
// ship_motion: frame-tick detect, ALIVE/HIT blink FSM and ship x position.
// Ports:
//   Clk, Reset          - pixel clock, async active-high reset
//   frame_clk           - frame level from VGA; its rising edge is the tick
//   keycode             - sampled on tick: KEY_LEFT / KEY_RIGHT move by STEP
//   hit                 - collision pulse, enters HIT from ALIVE
//   ship_x              - top-left x, clamped to [0, SCREEN_W - sprite width]
//   alive               - 1 in ALIVE, 0 in HIT
//   blink_cnt           - ticks elapsed in HIT, drives the blink
module ship_motion
   import ship_pkg::*;
#(
   parameter int SCALE_SHIFT  = 1,
   parameter int STEP         = 2,
   parameter int X_START      = 304,
   parameter int BLINK_FRAMES = 60
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   input  logic       hit,
   output logic [9:0] ship_x,
   output logic       alive,
   output logic [7:0] blink_cnt
);
   localparam logic [10:0] X_MAX = 11'(SCREEN_W - (SHIP_W << SCALE_SHIFT));
   ship_state_t r_state;
   logic        r_frame_q;
   logic [9:0]  r_ship_x;
   logic [7:0]  r_blink_cnt;
   logic        w_tick;
   logic [10:0] w_left, w_right, w_next_x;
   assign w_tick = frame_clk & ~r_frame_q;
   // 11-bit arithmetic: bit 10 of w_left flags a move past the left edge
   assign w_left   = {1'b0, r_ship_x} - 11'(STEP);
   assign w_right  = {1'b0, r_ship_x} + 11'(STEP);
   assign w_next_x = keycode == KEY_LEFT  ? (w_left[10] ? 11'd0 : w_left)
                   : keycode == KEY_RIGHT ? (w_right > X_MAX ? X_MAX : w_right)
                   : {1'b0, r_ship_x};
   assign ship_x    = r_ship_x;
   assign alive     = r_state == ALIVE;
   assign blink_cnt = r_blink_cnt;
   // A hit in ALIVE takes priority over a same-cycle tick, so no motion then
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         r_frame_q   <= 1'b0;
         r_state     <= ALIVE;
         r_blink_cnt <= '0;
         r_ship_x    <= 10'(X_START);
      end else begin
         r_frame_q <= frame_clk;
         if (r_state == ALIVE) begin
            if (hit) begin
               r_state     <= HIT;
               r_blink_cnt <= '0;
            end else if (w_tick)
               r_ship_x <= 10'(w_next_x);
         end else if (w_tick) begin
            if (r_blink_cnt == 8'(BLINK_FRAMES - 1))
               r_state <= ALIVE;
            else
               r_blink_cnt <= r_blink_cnt + 8'd1;
         end
      end
endmodule

// File: rtl/ship_sprite_renderer.sv
// ship_sprite_renderer: per-pixel ship flag from an external 16x8 bitmap ROM,
// scaled by 2^SCALE_SHIFT, with 2-cycle lookup latency at 1 pixel/cycle.
// Ports:
//   Clk, Reset          - pixel clock, async active-high reset
//   frame_clk, keycode  - frame tick and movement key (see ship_motion)
//   hit                 - collision pulse
//   DrawX, DrawY        - current pixel
//   rom_addr, rom_data  - ROM row address out, combinational row data in
//   is_ship             - lit ship pixel for DrawX/DrawY of 2 cycles earlier
//   ship_x, ship_y      - sprite top-left
//   alive               - 1 in ALIVE, 0 in HIT
module ship_sprite_renderer
   import ship_pkg::*;
#(
   parameter int SCALE_SHIFT  = 1,
   parameter int STEP         = 2,
   parameter int X_START      = 304,
   parameter int Y_START      = 440,
   parameter int BLINK_FRAMES = 60
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic [7:0]  keycode,
   input  logic        hit,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic [7:0]  rom_addr,
   input  logic [15:0] rom_data,
   output logic        is_ship,
   output logic [9:0]  ship_x,
   output logic [9:0]  ship_y,
   output logic        alive
);
   localparam logic [10:0] W = 11'(SHIP_W << SCALE_SHIFT);
   localparam logic [10:0] H = 11'(SHIP_H << SCALE_SHIFT);
   logic [7:0]  w_blink_cnt;
   logic [10:0] w_dx, w_dy;
   logic        w_in_box;
   logic        r_in_box_q, r_vis_q, r_is_ship;
   logic [3:0]  r_col_q;
   logic [2:0]  r_row_q;
   ship_motion #(
      .SCALE_SHIFT(SCALE_SHIFT), .STEP(STEP), .X_START(X_START), .BLINK_FRAMES(BLINK_FRAMES)
   ) u_motion (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode), .hit(hit),
      .ship_x(ship_x), .alive(alive), .blink_cnt(w_blink_cnt)
   );
   assign ship_y   = 10'(Y_START);
   // bit 10 of the offsets is the sign: pixel left of / above the sprite
   assign w_dx     = {1'b0, DrawX} - {1'b0, ship_x};
   assign w_dy     = {1'b0, DrawY} - 11'(Y_START);
   assign w_in_box = !w_dx[10] && w_dx < W && !w_dy[10] && w_dy < H;
   assign rom_addr = {5'b0, r_row_q};
   assign is_ship  = r_is_ship;
   // Stage 1 registers the row (ROM answers combinationally), stage 2 picks the column bit
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         r_in_box_q <= 1'b0;
         r_vis_q    <= 1'b0;
         r_col_q    <= '0;
         r_row_q    <= '0;
         r_is_ship  <= 1'b0;
      end else begin
         r_in_box_q <= w_in_box;
         r_col_q    <= 4'(w_dx >> SCALE_SHIFT);
         r_row_q    <= 3'(w_dy >> SCALE_SHIFT);
         r_vis_q    <= alive | ~w_blink_cnt[2];
         r_is_ship  <= r_in_box_q & r_vis_q & rom_data[4'd15 - r_col_q];
      end
endmodule

// File: tb/tb_ship_sprite_renderer.sv
// tb_ship_sprite_renderer: table vectors, directed motion/HIT sequences and a
// random pixel stream checked against a cycle-level reference model.
module tb_ship_sprite_renderer;
   logic        Clk = 0, Reset = 0, frame_clk = 0, hit = 0;
   logic [7:0]  keycode = 0;
   logic [9:0]  DrawX = 0, DrawY = 0;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic        is_ship, alive;
   logic [9:0]  ship_x, ship_y;
   logic [15:0] rom [8];
   int n_cmp = 0, n_bad = 0;
   int m_x, m_cnt;
   bit m_alive, m_fq;
   bit pq[$];
   typedef struct {int x; int y; int addr; bit ship; bit chk_addr;} vec_t;
   vec_t vt[11];

   ship_sprite_renderer dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode), .hit(hit),
      .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr), .rom_data(rom_data),
      .is_ship(is_ship), .ship_x(ship_x), .ship_y(ship_y), .alive(alive)
   );

   always #5 Clk = ~Clk;
   assign rom_data = rom[rom_addr[2:0]];

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   // expected pixel from the sprite rules: 2x scaled 16x8 bitmap at (m_x, 440)
   function automatic bit pix(input int x, input int y);
      int dx = x - m_x;
      int dy = y - 440;
      logic [15:0] row;
      if (dx < 0 || dx >= 32 || dy < 0 || dy >= 16) return 0;
      if (!m_alive && ((m_cnt / 4) % 2 == 1)) return 0;
      row = rom[dy / 2];
      return row[15 - dx / 2];
   endfunction

   function automatic void step(input bit fc, input bit h, input logic [7:0] key);
      bit tk = fc && !m_fq;
      m_fq = fc;
      if (m_alive) begin
         if (h) begin
            m_alive = 0;
            m_cnt = 0;
         end else if (tk) begin
            if (key == 8'h04) m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
            else if (key == 8'h07) m_x = (m_x + 2 > 608) ? 608 : m_x + 2;
         end
      end else if (tk) begin
         if (m_cnt == 59) m_alive = 1;
         else m_cnt++;
      end
   endfunction

   task automatic cyc(input bit fc, input bit h, input logic [7:0] key, input int x, input int y);
      @(negedge Clk);
      check("is_ship", is_ship, pq.pop_front());
      check("ship_x", ship_x, m_x);
      check("alive", alive, m_alive);
      frame_clk = fc; hit = h; keycode = key; DrawX = 10'(x); DrawY = 10'(y);
      pq.push_back(pix(x, y));
      step(fc, h, key);
   endtask

   task automatic tick(input logic [7:0] key, input int x, input int y);
      cyc(1, 0, key, x, y);
      cyc(0, 0, key, x, y);
   endtask

   task automatic rst();
      @(negedge Clk);
      Reset = 1; frame_clk = 0; hit = 0; keycode = 0; DrawX = 0; DrawY = 0;
      #1;
      check("rst ship_x", ship_x, 304);
      check("rst ship_y", ship_y, 440);
      check("rst alive", alive, 1);
      check("rst is_ship", is_ship, 0);
      check("rst rom_addr", rom_addr, 0);
      @(negedge Clk);
      Reset = 0;
      m_x = 304; m_alive = 1; m_cnt = 0; m_fq = 0;
      pq.delete();
      pq.push_back(0);
      pq.push_back(0);
   endtask

   function automatic int rx();
      int x = m_x + int'($urandom_range(0, 40)) - 4;
      return x < 0 ? 0 : (x > 639 ? 639 : x);
   endfunction

   function automatic int ry();
      return 436 + int'($urandom_range(0, 24)) > 479 ? 479 : 436 + int'($urandom_range(0, 24));
   endfunction

   initial begin
      int x0;
      rom = '{16'h8001, 16'h0180, 16'h03C0, 16'h07E0, 16'h0FF0, 16'h1FF8, 16'h3FFC, 16'hFFFF};
      vt = '{'{318, 442, 1, 1, 1}, '{304, 442, 1, 0, 1}, '{303, 442, 0, 0, 0},
             '{318, 456, 0, 0, 0}, '{304, 440, 0, 1, 1}, '{335, 440, 0, 1, 1},
             '{336, 440, 0, 0, 0}, '{335, 455, 7, 1, 1}, '{320, 446, 3, 1, 1},
             '{305, 446, 3, 0, 1}, '{318, 439, 0, 0, 0}};
      rst();
      foreach (vt[i]) begin
         repeat (3) cyc(0, 0, 0, vt[i].x, vt[i].y);
         check($sformatf("vec%0d is_ship", i), is_ship, vt[i].ship);
         if (vt[i].chk_addr) check($sformatf("vec%0d rom_addr", i), rom_addr, vt[i].addr);
      end
      repeat (153) tick(8'h04, rx(), ry());
      check("left clamp", ship_x, 0);
      repeat (310) tick(8'h07, rx(), ry());
      check("right clamp", ship_x, 608);
      // hit, then 60 ticks holding right while watching a lit pixel (row 7, col 0)
      x0 = m_x;
      cyc(0, 1, 0, m_x, 454);
      for (int i = 0; i < 60; i++) begin
         tick(8'h07, x0, 454);
         if (i == 58) begin
            check("x frozen in HIT", ship_x, x0);
            check("still HIT", alive, 0);
         end
      end
      cyc(0, 0, 0, x0, 454);
      check("alive after blink", alive, 1);
      repeat (20) tick(8'h04, rx(), ry());
      // hit and tick in the same cycle; a second hit does not extend HIT
      x0 = m_x;
      cyc(1, 1, 8'h07, m_x, 454);
      cyc(0, 0, 8'h07, m_x, 454);
      check("hit+tick x", ship_x, x0);
      check("hit+tick state", alive, 0);
      repeat (10) tick(8'h07, rx(), ry());
      cyc(0, 1, 0, rx(), ry());
      repeat (49) tick(8'h07, rx(), ry());
      check("second hit ignored pre", alive, 0);
      tick(8'h07, rx(), ry());
      cyc(0, 0, 0, rx(), ry());
      check("second hit ignored", alive, 1);
      // reset in the middle of HIT at x = 100
      for (int i = 0; i < 400 && m_x != 100; i++) tick(m_x > 100 ? 8'h04 : 8'h07, rx(), ry());
      check("reach 100", ship_x, 100);
      cyc(0, 1, 0, 100, 454);
      repeat (5) tick(8'h04, 100, 454);
      rst();
      // random full-rate pixel stream with sporadic ticks, keys and hits
      for (int i = 0; i < 3000; i++) begin
         int k = $urandom_range(0, 2);
         cyc($urandom_range(0, 9) == 0, $urandom_range(0, 299) == 0,
             k == 0 ? 8'h04 : (k == 1 ? 8'h07 : 8'($urandom)), rx(), ry());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ship_sprite_renderer.md
Name: ship_sprite_renderer

Overview:
- Sits between the VGA controller and the colour mapper. It consumes rows from the 16x8 ship bitmap ROM and produces a per-pixel is_ship flag.
- Holds the ship's top-left position and updates it once per frame from the keyboard keycode, clamping at the screen edges.
- Runs a HIT blink state machine after a collision pulse.
- Pixel lookup is a 2-stage pipeline; the bitmap is drawn scaled by 2^SCALE_SHIFT.

Parameters:
- SCALE_SHIFT, 1, log2 of the pixel scale factor; the on-screen sprite is (16<<SCALE_SHIFT) x (8<<SCALE_SHIFT).
- STEP, 2, pixels moved per frame while a direction key is held.
- X_START, 304, reset x position (top-left).
- Y_START, 440, fixed y position (top-left).
- BLINK_FRAMES, 60, number of frames spent in HIT.

Ports:
- Clk  in  1  system clock (pixel clock domain).
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  level from the VGA controller, same clock domain; its rising edge marks the frame tick.
- keycode  in  8  current USB keycode; 8'h04 = left (A), 8'h07 = right (D), anything else = no motion.
- hit  in  1  single-cycle collision pulse.
- DrawX  in  10  current pixel column, 0..639.
- DrawY  in  10  current pixel row, 0..479.
- rom_addr  out  8  row address to the ship ROM; bits [7:3] are always 0.
- rom_data  in  16  ROM row, combinational from rom_addr; bit 15 is the leftmost column.
- is_ship  out  1  the pixel presented 2 cycles earlier is a lit ship pixel.
- ship_x  out  10  current top-left x.
- ship_y  out  10  current top-left y (constant Y_START).
- alive  out  1  1 in ALIVE, 0 in HIT.

Behaviour:
- Reset (async, active-high) values:
  - ship_x = X_START, ship_y = Y_START, state = ALIVE, alive = 1.
  - blink counter = 0, is_ship = 0, rom_addr = 0.
  - All pipeline registers = 0, frame_clk_q = 0.
  - Reset asserted mid-HIT or mid-frame returns immediately to these values. No partial motion survives.
- Frame tick:
  - tick = frame_clk & ~frame_clk_q, with frame_clk_q registered every Clk.
  - keycode is sampled only on the tick cycle.
- Motion, applied only on a tick and only in ALIVE:
  - Left: ship_x = max(ship_x - STEP, 0). Compute in 11 bits; no underflow wrap.
  - Right: ship_x = min(ship_x + STEP, 640 - W), where W = 16<<SCALE_SHIFT (608 at the defaults).
- FSM states: ALIVE, HIT.
  - ALIVE -> HIT when hit = 1; blink counter is loaded with 0.
  - HIT: the counter increments on each tick. HIT -> ALIVE on the tick where counter == BLINK_FRAMES-1.
  - hit while already in HIT is ignored; the counter does not restart.
  - hit and tick in the same cycle: the transition wins and motion for that tick is suppressed.
- Pixel pipeline; DrawX/DrawY are presented at cycle n:
  - Stage 1 (registered at n+1):
    - dx = DrawX - ship_x, dy = DrawY - ship_y, both 11-bit signed.
    - in_box_q = (dx >= 0 && dx < W && dy >= 0 && dy < H), where H = 8<<SCALE_SHIFT.
    - col_q = dx >> SCALE_SHIFT (4 bits).
    - rom_addr = {5'b0, dy >> SCALE_SHIFT}.
    - vis_q = alive | (blink_cnt[2] == 0), so the ship blinks with a 4-frame on/off period while in HIT.
  - Stage 2 (registered at n+2): is_ship = in_box_q & vis_q & rom_data[15 - col_q].
  - Total latency: 2 Clk cycles. Throughput: 1 pixel per cycle.
  - When not in_box, rom_addr may take any value in 0..7; is_ship must still be 0.
- Position stability during a frame:
  - ship_x changes only on the tick cycle.
  - A pixel sampled in the tick cycle uses the pre-update ship_x.

Decomposition:
- Package ship_pkg holds:
  - SHIP_W = 16, SHIP_H = 8, SCREEN_W = 640, SCREEN_H = 480.
  - KEY_LEFT = 8'h04, KEY_RIGHT = 8'h07.
  - typedef enum logic {ALIVE, HIT} ship_state_t.
- One sub-module, ship_motion, contains the tick detect, the FSM, the blink counter and the ship_x register, and outputs ship_x, alive and blink_cnt.
- The top level contains the 2-stage pixel pipeline.
- The ROM stays external and is connected through rom_addr/rom_data.

Test Plan:
- Reset, then DrawX = 304 + 2*7 = 318, DrawY = 440 + 2*1 = 442 -> rom_addr = 1, is_ship = 1 two cycles later. Row 1 = 0000000110000000, and col 7 is lit.
- Same row with DrawX = 304 (col 0) -> is_ship = 0 at n+2. DrawX = 303 or DrawY = 456 -> is_ship = 0 (outside the box).
- Hold keycode 8'h04 for 153 ticks from reset -> ship_x goes 304, 302, …, 0 and stays at 0. Hold 8'h07 from 606 -> ship_x = 608 and stays there.
- Pulse hit, then hold 8'h07 for 60 ticks:
  - alive = 0 and ship_x unchanged throughout.
  - is_ship at a lit pixel is 0 exactly while blink_cnt[2] = 1.
  - alive returns to 1 after tick 60.
- hit on the same cycle as a tick with keycode 8'h07 -> ship_x unchanged and state = HIT. A second hit 10 ticks later does not extend HIT beyond 60 ticks.
- Assert Reset mid-HIT at ship_x = 100 -> immediately ship_x = 304, alive = 1, is_ship = 0.
